// File: rtl/mlp_stream_scheduler.sv
// Purpose: packet round-robin arbiter sharing one MLP pipeline among NREQ streams, returns steered by TID.
// Latency: one IDLE arbitration cycle per packet; issue and return beats are pure combinational muxes.
// Backpressure: P_TX_TREADY passes to the granted requester only; P_RX_TREADY follows the addressed R_TREADY.
// Optional MLP_SCHED_STATS_EN adds PKT_ISSUED / PKT_RETURNED packet counters.
module mlp_stream_scheduler #(
    parameter int              NREQ            = 4,
    parameter int              DATAW           = 512,
    parameter int              IDW             = 8,
    parameter int              USERW           = 8,
    parameter int              DESTW           = 8,
    parameter logic [DESTW-1:0] DEST_CFG       = '0,
    parameter int              MAX_OUTSTANDING = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NREQ-1:0]         S_TVALID,
    output logic [NREQ-1:0]         S_TREADY,
    input  logic [NREQ*DATAW-1:0]   S_TDATA,
    input  logic [NREQ-1:0]         S_TLAST,
    input  logic [NREQ*USERW-1:0]   S_TUSER,
    output logic                    P_TX_TVALID,
    input  logic                    P_TX_TREADY,
    output logic [DATAW-1:0]        P_TX_TDATA,
    output logic                    P_TX_TLAST,
    output logic [IDW-1:0]          P_TX_TID,
    output logic [USERW-1:0]        P_TX_TUSER,
    output logic [DESTW-1:0]        P_TX_TDEST,
    input  logic                    P_RX_TVALID,
    output logic                    P_RX_TREADY,
    input  logic [DATAW-1:0]        P_RX_TDATA,
    input  logic                    P_RX_TLAST,
    input  logic [IDW-1:0]          P_RX_TID,
    input  logic [USERW-1:0]        P_RX_TUSER,
    output logic [NREQ-1:0]         R_TVALID,
    input  logic [NREQ-1:0]         R_TREADY,
    output logic [DATAW-1:0]        R_TDATA,
    output logic                    R_TLAST,
    output logic [USERW-1:0]        R_TUSER,
    output logic [3:0]              OUTSTANDING,
    output logic                    ERR
`ifdef MLP_SCHED_STATS_EN
    ,
    output logic [31:0]             PKT_ISSUED,
    output logic [31:0]             PKT_RETURNED
`endif
);

    localparam int         GW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   grant_idx;
    logic [GW-1:0]   rr_ptr;
    logic [3:0]      outstanding;
    logic            err;

    logic            gnt_found;
    logic [GW-1:0]   gnt_next;
    int              cand;
    logic [GW-1:0]   cand_idx;
    logic            credit_ok;
    logic            grant_en;
    logic            tx_last_hs;
    logic            rx_tid_ok;
    logic            rx_hs;
    logic            rx_last_hs;
    logic            err_set;

    assign credit_ok = (outstanding < MAX_OUT);

    // Circular search for the first valid requester at or after rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_next  = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NREQ;
            cand_idx = GW'(cand);
            if (!gnt_found && S_TVALID[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_next  = cand_idx;
            end
        end
    end

    // Next-state logic: grant in IDLE when credit allows, release on the issued TLAST.
    always_comb begin
        state_nxt  = state;
        grant_en   = 1'b0;
        tx_last_hs = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found && credit_ok) begin
                    grant_en  = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (P_TX_TVALID && P_TX_TREADY && P_TX_TLAST) begin
                    tx_last_hs = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue path: mux of the granted requester, gated to zero valid/ready outside STREAM.
    always_comb begin
        P_TX_TVALID = 1'b0;
        P_TX_TDATA  = '0;
        P_TX_TLAST  = 1'b0;
        P_TX_TUSER  = '0;
        S_TREADY    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == GW'(i)) begin
                P_TX_TDATA = S_TDATA[i*DATAW +: DATAW];
                P_TX_TLAST = S_TLAST[i];
                P_TX_TUSER = S_TUSER[i*USERW +: USERW];
                if (state == STREAM) begin
                    P_TX_TVALID = S_TVALID[i];
                    S_TREADY[i] = P_TX_TREADY;
                end
            end
        end
    end

    assign P_TX_TID   = IDW'(grant_idx);
    assign P_TX_TDEST = DEST_CFG;

    // Return path: steer by TID; out-of-range IDs are swallowed so the pipeline never stalls.
    always_comb begin
        rx_tid_ok   = (P_RX_TID < IDW'(NREQ));
        R_TVALID    = '0;
        P_RX_TREADY = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (P_RX_TID == IDW'(i)) begin
                R_TVALID[i] = P_RX_TVALID;
                P_RX_TREADY = R_TREADY[i];
            end
        end
    end

    assign R_TDATA    = P_RX_TDATA;
    assign R_TLAST    = P_RX_TLAST;
    assign R_TUSER    = P_RX_TUSER;

    assign rx_hs      = P_RX_TVALID & P_RX_TREADY;
    assign rx_last_hs = rx_hs & P_RX_TLAST;
    assign err_set    = (rx_hs & ~rx_tid_ok) | (rx_last_hs & (outstanding == 4'd0));

    // FSM, grant latch and round-robin pointer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            state <= state_nxt;
            if (grant_en) begin
                grant_idx <= gnt_next;
            end
            if (tx_last_hs) begin
                if (grant_idx == GW'(NREQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + GW'(1);
                end
            end
        end
    end

    // Credit counter: reserved at grant, released on returned TLAST, never underflows.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            outstanding <= 4'd0;
        end else begin
            case ({grant_en, rx_last_hs})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   if (outstanding != 4'd0) outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky error: bad return TID or a return TLAST with no credit outstanding.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    assign OUTSTANDING = outstanding;
    assign ERR         = err;

`ifdef MLP_SCHED_STATS_EN
    // Free-running packet counters, wrapping modulo 2^32.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PKT_ISSUED   <= '0;
            PKT_RETURNED <= '0;
        end else begin
            if (tx_last_hs) PKT_ISSUED   <= PKT_ISSUED + 32'd1;
            if (rx_last_hs) PKT_RETURNED <= PKT_RETURNED + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mlp_stream_scheduler.sv
module tb_mlp_stream_scheduler;

    localparam int NREQ  = 4;
    localparam int DATAW = 32;
    localparam int IDW   = 8;
    localparam int USERW = 8;
    localparam int DESTW = 8;
    localparam int MAXO  = 2;

    logic                  CLK = 1'b0;
    logic                  RST_N;
    logic [NREQ-1:0]       S_TVALID;
    logic [NREQ-1:0]       S_TREADY;
    logic [NREQ*DATAW-1:0] S_TDATA;
    logic [NREQ-1:0]       S_TLAST;
    logic [NREQ*USERW-1:0] S_TUSER;
    logic                  P_TX_TVALID;
    logic                  P_TX_TREADY;
    logic [DATAW-1:0]      P_TX_TDATA;
    logic                  P_TX_TLAST;
    logic [IDW-1:0]        P_TX_TID;
    logic [USERW-1:0]      P_TX_TUSER;
    logic [DESTW-1:0]      P_TX_TDEST;
    logic                  P_RX_TVALID;
    logic                  P_RX_TREADY;
    logic [DATAW-1:0]      P_RX_TDATA;
    logic                  P_RX_TLAST;
    logic [IDW-1:0]        P_RX_TID;
    logic [USERW-1:0]      P_RX_TUSER;
    logic [NREQ-1:0]       R_TVALID;
    logic [NREQ-1:0]       R_TREADY;
    logic [DATAW-1:0]      R_TDATA;
    logic                  R_TLAST;
    logic [USERW-1:0]      R_TUSER;
    logic [3:0]            OUTSTANDING;
    logic                  ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mlp_stream_scheduler #(
        .NREQ(NREQ), .DATAW(DATAW), .IDW(IDW), .USERW(USERW), .DESTW(DESTW),
        .DEST_CFG(8'h5A), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA),
        .S_TLAST(S_TLAST), .S_TUSER(S_TUSER),
        .P_TX_TVALID(P_TX_TVALID), .P_TX_TREADY(P_TX_TREADY), .P_TX_TDATA(P_TX_TDATA),
        .P_TX_TLAST(P_TX_TLAST), .P_TX_TID(P_TX_TID), .P_TX_TUSER(P_TX_TUSER),
        .P_TX_TDEST(P_TX_TDEST),
        .P_RX_TVALID(P_RX_TVALID), .P_RX_TREADY(P_RX_TREADY), .P_RX_TDATA(P_RX_TDATA),
        .P_RX_TLAST(P_RX_TLAST), .P_RX_TID(P_RX_TID), .P_RX_TUSER(P_RX_TUSER),
        .R_TVALID(R_TVALID), .R_TREADY(R_TREADY), .R_TDATA(R_TDATA),
        .R_TLAST(R_TLAST), .R_TUSER(R_TUSER),
        .OUTSTANDING(OUTSTANDING), .ERR(ERR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N       = 1'b0;
        S_TVALID    = '0;
        S_TLAST     = '0;
        S_TDATA     = '0;
        S_TUSER     = '0;
        P_TX_TREADY = 1'b1;
        P_RX_TVALID = 1'b0;
        P_RX_TDATA  = '0;
        P_RX_TLAST  = 1'b0;
        P_RX_TID    = '0;
        P_RX_TUSER  = '0;
        R_TREADY    = '1;
        for (int i = 0; i < NREQ; i++) begin
            S_TDATA[i*DATAW +: DATAW] = 32'hA0 + 32'(i);
            S_TUSER[i*USERW +: USERW] = 8'h10 + 8'(i);
        end
        #2;
        chk("rst_s_tready", S_TREADY, 0);
        chk("rst_tx_tvalid", P_TX_TVALID, 0);
        chk("rst_outstanding", OUTSTANDING, 0);
        chk("rst_err", ERR, 0);
        chk("rst_r_tvalid", R_TVALID, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc();

        // Fairness: all requesters valid, 1-beat packets, each returned while it streams
        S_TVALID = 4'hF;
        S_TLAST  = 4'hF;
        for (int k = 0; k < 8; k++) begin
            P_RX_TVALID = 1'b0;
            #2;
            chk("fair_bubble_vld", P_TX_TVALID, 0);
            chk("fair_bubble_rdy", S_TREADY, 0);
            cyc();
            P_RX_TVALID = 1'b1;
            P_RX_TLAST  = 1'b1;
            P_RX_TID    = 8'(k % 4);
            #2;
            chk("fair_tid", P_TX_TID, k % 4);
            chk("fair_rdy", S_TREADY, 1 << (k % 4));
            chk("fair_data", P_TX_TDATA, 32'hA0 + (k % 4));
            chk("fair_user", P_TX_TUSER, 8'h10 + (k % 4));
            chk("fair_out", OUTSTANDING, 1);
            cyc();
        end
        S_TVALID    = '0;
        S_TLAST     = '0;
        P_RX_TVALID = 1'b0;
        P_RX_TLAST  = 1'b0;
        #2;
        chk("fair_out_end", OUTSTANDING, 0);
        chk("fair_err", ERR, 0);
        cyc();

        // Single packet: requester 2, 3 beats
        S_TVALID = 4'b0100;
        S_TDATA[2*DATAW +: DATAW] = 32'hB0;
        #2;
        chk("sp_idle_rdy", S_TREADY, 0);
        chk("sp_idle_vld", P_TX_TVALID, 0);
        cyc();
        for (int b = 0; b < 3; b++) begin
            S_TDATA[2*DATAW +: DATAW] = 32'hB0 + 32'(b);
            S_TLAST[2] = (b == 2);
            #2;
            chk("sp_vld", P_TX_TVALID, 1);
            chk("sp_tid", P_TX_TID, 2);
            chk("sp_dest", P_TX_TDEST, 8'h5A);
            chk("sp_data", P_TX_TDATA, 32'hB0 + b);
            chk("sp_last", P_TX_TLAST, (b == 2));
            chk("sp_rdy", S_TREADY, 4'b0100);
            chk("sp_out", OUTSTANDING, 1);
            cyc();
        end
        S_TVALID = '0;
        S_TLAST  = '0;
        #2;
        chk("sp_done_vld", P_TX_TVALID, 0);
        R_TREADY    = 4'b1011;
        P_RX_TVALID = 1'b1;
        P_RX_TID    = 8'd2;
        #2;
        chk("sp_backpressure", P_RX_TREADY, 0);
        R_TREADY = '1;
        for (int b = 0; b < 3; b++) begin
            P_RX_TVALID = 1'b1;
            P_RX_TID    = 8'd2;
            P_RX_TDATA  = 32'hC0 + 32'(b);
            P_RX_TUSER  = 8'h30 + 8'(b);
            P_RX_TLAST  = (b == 2);
            #2;
            chk("sp_r_tvalid", R_TVALID, 4'b0100);
            chk("sp_rx_tready", P_RX_TREADY, 1);
            chk("sp_r_tdata", R_TDATA, 32'hC0 + b);
            chk("sp_r_tuser", R_TUSER, 8'h30 + b);
            chk("sp_r_tlast", R_TLAST, (b == 2));
            chk("sp_ret_out", OUTSTANDING, 1);
            cyc();
        end
        P_RX_TVALID = 1'b0;
        P_RX_TLAST  = 1'b0;
        #2;
        chk("sp_out_end", OUTSTANDING, 0);
        chk("sp_r_tvalid_off", R_TVALID, 0);

        // Credit stall with MAX_OUTSTANDING=2, requester 0 only, 1-beat packets
        S_TVALID = 4'b0001;
        S_TLAST  = 4'b0001;
        cyc();
        #2;
        chk("cs_tid_a", P_TX_TID, 0);
        cyc();
        cyc();
        cyc();
        #2;
        chk("cs_stall_rdy", S_TREADY, 0);
        chk("cs_stall_vld", P_TX_TVALID, 0);
        chk("cs_stall_out", OUTSTANDING, 2);
        cyc();
        P_RX_TVALID = 1'b1;
        P_RX_TLAST  = 1'b1;
        P_RX_TID    = 8'd0;
        #2;
        chk("cs_stall_rdy2", S_TREADY, 0);
        cyc();
        P_RX_TVALID = 1'b0;
        #2;
        chk("cs_release_out", OUTSTANDING, 1);
        chk("cs_release_idle", P_TX_TVALID, 0);
        cyc();
        #2;
        chk("cs_regrant_vld", P_TX_TVALID, 1);
        chk("cs_regrant_out", OUTSTANDING, 2);
        P_RX_TVALID = 1'b1;
        cyc();
        // grant and return TLAST in the same cycle with one credit out
        #2;
        chk("si_pre_out", OUTSTANDING, 1);
        chk("si_pre_idle", P_TX_TVALID, 0);
        cyc();
        P_RX_TVALID = 1'b0;
        #2;
        chk("si_stream_vld", P_TX_TVALID, 1);
        chk("si_out", OUTSTANDING, 1);
        cyc();
        S_TVALID    = '0;
        S_TLAST     = '0;
        P_RX_TVALID = 1'b1;
        cyc();
        P_RX_TVALID = 1'b0;
        P_RX_TLAST  = 1'b0;
        #2;
        chk("cs_drain_out", OUTSTANDING, 0);
        chk("cs_err", ERR, 0);
        cyc();

        // Error: out-of-range TID is swallowed
        R_TREADY    = '0;
        P_RX_TVALID = 1'b1;
        P_RX_TID    = 8'd7;
        P_RX_TLAST  = 1'b0;
        #2;
        chk("er_rx_tready", P_RX_TREADY, 1);
        chk("er_r_tvalid", R_TVALID, 0);
        chk("er_err_pre", ERR, 0);
        cyc();
        P_RX_TVALID = 1'b0;
        #2;
        chk("er_err", ERR, 1);
        chk("er_out", OUTSTANDING, 0);
        RST_N = 1'b0;
        #1;
        chk("er_rst_clear", ERR, 0);
        RST_N    = 1'b1;
        R_TREADY = '1;
        cyc();

        // Error: return TLAST with no credit outstanding
        P_RX_TVALID = 1'b1;
        P_RX_TID    = 8'd1;
        P_RX_TLAST  = 1'b1;
        #2;
        chk("uf_r_tvalid", R_TVALID, 4'b0010);
        cyc();
        P_RX_TVALID = 1'b0;
        P_RX_TLAST  = 1'b0;
        #2;
        chk("uf_err", ERR, 1);
        chk("uf_out", OUTSTANDING, 0);
        RST_N = 1'b0;
        #1;
        RST_N = 1'b1;
        cyc();

        // Reset mid-packet: move rr_ptr to 2, then abort a 4-beat packet from requester 3
        S_TVALID = 4'b0010;
        S_TLAST  = 4'b0010;
        cyc();
        cyc();
        S_TVALID = 4'b1001;
        S_TLAST  = 4'b0000;
        cyc();
        #2;
        chk("rm_tid_b1", P_TX_TID, 3);
        cyc();
        #2;
        chk("rm_vld_b2", P_TX_TVALID, 1);
        chk("rm_out_b2", OUTSTANDING, 2);
        RST_N = 1'b0;
        #1;
        chk("rm_rdy", S_TREADY, 0);
        chk("rm_vld", P_TX_TVALID, 0);
        chk("rm_out", OUTSTANDING, 0);
        #1;
        RST_N = 1'b1;
        cyc();
        #2;
        chk("rm_first_tid", P_TX_TID, 0);
        chk("rm_first_rdy", S_TREADY, 4'b0001);
        chk("rm_first_out", OUTSTANDING, 1);
        S_TVALID = '0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mlp_stream_scheduler.md
# mlp_stream_scheduler

Packet-granular round-robin scheduler that shares one two-stage MLP pipeline (an AXI-Stream chain of input passthrough, two MVM stages and output passthrough) among NREQ independent AXI-Stream requesters. It tags each issued packet with the requester index in TID and holds a credit count of packets in flight. Results coming back from the pipeline are steered to the originating requester by TID. It sits between the host-side stream sources and the MLP pipeline top.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATAW, 512, stream data width
- IDW, 8, TID width; must satisfy IDW >= $clog2(NREQ)
- USERW, 8, TUSER width
- DESTW, 8, TDEST width
- DEST_CFG, 0, constant TDEST driven on issued beats
- MAX_OUTSTANDING, 4, maximum packets in flight (1..15)

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset; asynchronous assert, active-low
- S_TVALID  in  NREQ  requester valid, one bit per requester
- S_TREADY  out  NREQ  requester ready
- S_TDATA  in  NREQ*DATAW  requester data; requester i occupies slice [i*DATAW +: DATAW]
- S_TLAST  in  NREQ  requester end-of-packet
- S_TUSER  in  NREQ*USERW  requester user field
- P_TX_TVALID / P_TX_TREADY  out / in  1  issue to pipeline
- P_TX_TDATA  out  DATAW  issue data
- P_TX_TLAST  out  1  issue end-of-packet
- P_TX_TID  out  IDW  issue ID (requester index)
- P_TX_TUSER  out  USERW  issue user field
- P_TX_TDEST  out  DESTW  issue destination
- P_RX_TVALID / P_RX_TREADY  in / out  1  result from pipeline
- P_RX_TDATA  in  DATAW  result data
- P_RX_TLAST  in  1  result end-of-packet
- P_RX_TID  in  IDW  result ID
- P_RX_TUSER  in  USERW  result user field
- R_TVALID  out  NREQ  per-requester result valid
- R_TREADY  in  NREQ  per-requester result ready
- R_TDATA  out  DATAW  shared result data bus
- R_TLAST  out  1  shared result end-of-packet
- R_TUSER  out  USERW  shared result user field
- OUTSTANDING  out  4  packets currently in flight
- ERR  out  1  sticky error flag; cleared only by reset

## Operation
- FSM states: IDLE, STREAM.
- IDLE:
  - If any S_TVALID is set and OUTSTANDING < MAX_OUTSTANDING, grant the first valid requester at or after rr_ptr, searching circularly.
  - On grant: latch grant index, increment OUTSTANDING, go to STREAM. All S_TREADY are 0 in IDLE.
- STREAM:
  - P_TX_* is a combinational mux of the granted requester. TID = grant index, zero-extended. TDEST = DEST_CFG.
  - S_TREADY[grant] = P_TX_TREADY. All other S_TREADY bits are 0.
  - On a handshake with TLAST: set rr_ptr = grant+1 mod NREQ, go to IDLE.
- Return path (combinational):
  - If P_RX_TID < NREQ: R_TVALID[P_RX_TID] = P_RX_TVALID and P_RX_TREADY = R_TREADY[P_RX_TID].
  - If P_RX_TID >= NREQ: P_RX_TREADY = 1, the beat is dropped and ERR is set.
  - R_TDATA, R_TLAST and R_TUSER are broadcast to all requesters.
- Credit accounting:
  - Decrement OUTSTANDING on a P_RX handshake with TLAST, including dropped beats.
  - Grant-increment and return-decrement in the same cycle leave the count unchanged.
  - A return TLAST while OUTSTANDING == 0: hold at 0 and set ERR.
- Credit is reserved at grant, so a packet being streamed always holds its credit.

## Timing
- Reset values: FSM IDLE, rr_ptr 0, OUTSTANDING 0, ERR 0, all S_TREADY 0, P_TX_TVALID 0. R_TVALID follows P_RX_TVALID combinationally.
- Arbitration costs exactly one cycle (IDLE) per packet. Back-to-back packets therefore have a one-cycle bubble.
- No added latency on issue or return beats; both are pure muxes.
- Reset asserted mid-packet: the FSM aborts immediately and all credits are lost (cleared to 0). The pipeline must be reset together with this block.
- P_TX_TVALID never drops during a packet unless the granted requester's S_TVALID drops. AXI-Stream rules are passed through unmodified.

## Configuration
- MLP_SCHED_STATS_EN defined:
  - Adds output PKT_ISSUED [31:0], counting issued TLAST handshakes.
  - Adds output PKT_RETURNED [31:0], counting returned TLAST handshakes.
  - Both counters reset to 0 and wrap modulo 2^32.
- MLP_SCHED_STATS_EN undefined: neither port nor its counter exists. All other behaviour is identical.

## Test plan
- Single packet: requester 2 sends 3 beats. Expect IDLE→STREAM after 1 cycle, P_TX_TID=2, OUTSTANDING=1. When 3 result beats return with TID=2, R_TVALID=4'b0100 and OUTSTANDING returns to 0.
- Fairness: all 4 requesters continuously valid with 1-beat packets. Grant order 0,1,2,3,0…, with one bubble between packets.
- Credit stall: MAX_OUTSTANDING=2 and no returns. The third packet is not granted (S_TREADY=0, FSM stays IDLE). One returned TLAST releases the grant on the next cycle.
- Simultaneous events: grant and return TLAST in the same cycle with OUTSTANDING=1. OUTSTANDING stays 1.
- Errors: return TID=7 with NREQ=4 → beat is accepted, no R_TVALID asserted, ERR=1. A return TLAST with OUTSTANDING=0 → ERR=1 and the count stays 0.
- Reset mid-packet: assert RST_N=0 on beat 2 of 4. All outputs take their reset values asynchronously; after release, requester 0 is granted first.
